// File: rtl/run_ctrl_if.sv
// Data-memory bus and dump stream between run_ctrl and the dmem/consumer side.
// master = run_ctrl, slave = memory plus dump consumer.
interface run_ctrl_if;
  logic        MEM_RD_WRN;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        DUMP_VALID;
  logic        DUMP_READY;
  logic [31:0] DUMP_ADDR;
  logic [31:0] DUMP_DATA;

  modport master (
    output MEM_RD_WRN, MEM_ADDR, MEM_WDATA, DUMP_VALID, DUMP_ADDR, DUMP_DATA,
    input  MEM_RDATA, DUMP_READY
  );

  modport slave (
    input  MEM_RD_WRN, MEM_ADDR, MEM_WDATA, DUMP_VALID, DUMP_ADDR, DUMP_DATA,
    output MEM_RDATA, DUMP_READY
  );
endinterface

// File: rtl/run_ctrl.sv
// Run/dump controller: holds the CPU in reset, runs it for a cycle budget, then
// sweeps dmem out over a valid/ready stream. Define RUN_CTRL_SYNC_EN to add 2-flop input synchronizers.
module run_ctrl #(
  parameter int DMEM_DEPTH = 10,
  parameter int CNT_W      = 32
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic              RUN_REQ,
  input  logic              DUMP_REQ,
  input  logic [CNT_W-1:0]  CYCLE_LIMIT,
  output logic              CPU_RST_N,
  input  logic              CPU_DMEM_RD_WRN,
  input  logic [31:0]       CPU_DMEM_ADDR,
  input  logic [31:0]       CPU_DMEM_WDATA,
  run_ctrl_if.master        bus,
  output logic [1:0]        STATE,
  output logic [CNT_W-1:0]  CYCLE_COUNT
);

  localparam int PTR_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             run_lvl, dump_lvl;
  logic             run_prev_q;
  logic             run_rise;
  logic             limit_hit;
  logic             dump_xfer;

`ifdef RUN_CTRL_SYNC_EN
  logic [1:0] run_sync_q, dump_sync_q;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      run_sync_q  <= '0;
      dump_sync_q <= '0;
    end else begin
      run_sync_q  <= {run_sync_q[0], RUN_REQ};
      dump_sync_q <= {dump_sync_q[0], DUMP_REQ};
    end
  end

  assign run_lvl  = run_sync_q[1];
  assign dump_lvl = dump_sync_q[1];
`else
  assign run_lvl  = RUN_REQ;
  assign dump_lvl = DUMP_REQ;
`endif

  // NOTE: reset is sampled synchronously and all state uses non-blocking assignment
  // so every register sees pre-edge values of its neighbours.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      ptr_q      <= '0;
      run_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      run_prev_q <= run_lvl;
    end
  end

  assign run_rise  = run_lvl & ~run_prev_q;
  assign limit_hit = (CYCLE_LIMIT != '0) && (cnt_q == CYCLE_LIMIT - CNT_W'(1));
  assign dump_xfer = (state_q == ST_DUMP) && bus.DUMP_READY;

  // NOTE: every variable gets a default before the case so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_HOLD: begin
        if (run_rise) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (!run_lvl || limit_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (run_rise) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (dump_lvl) begin
          state_d = ST_DUMP;
          ptr_d   = '0;
        end
      end
      ST_DUMP: begin
        // Request inputs are deliberately not looked at until the sweep ends.
        if (dump_xfer) begin
          if (ptr_q == PTR_LAST) begin
            state_d = ST_DONE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // The CPU only owns the dmem bus while it is out of reset.
  always_comb begin
    CPU_RST_N      = 1'b0;
    bus.MEM_RD_WRN = 1'b1;
    bus.MEM_ADDR   = '0;
    bus.MEM_WDATA  = '0;
    bus.DUMP_VALID = 1'b0;
    bus.DUMP_DATA  = '0;
    unique case (state_q)
      ST_RUN: begin
        CPU_RST_N      = 1'b1;
        bus.MEM_RD_WRN = CPU_DMEM_RD_WRN;
        bus.MEM_ADDR   = CPU_DMEM_ADDR;
        bus.MEM_WDATA  = CPU_DMEM_WDATA;
      end
      ST_DUMP: begin
        bus.MEM_ADDR   = 32'(ptr_q);
        bus.DUMP_VALID = 1'b1;
        bus.DUMP_DATA  = bus.MEM_RDATA;
      end
      default: ;
    endcase
  end

  assign bus.DUMP_ADDR = 32'(ptr_q);
  assign STATE         = state_q;
  assign CYCLE_COUNT   = cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: a cycle-level reference model queues expected
// outputs and dump words; a negedge monitor pops and compares.
module tb_run_ctrl;
  localparam int DEPTH = 10;
  localparam int CNT_W = 32;
  localparam int MEMW  = 16;
`ifdef RUN_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int M_HOLD = 0, M_RUN = 1, M_DONE = 2, M_DUMP = 3;

  logic             clk = 1'b0;
  logic             rst, run_req, dump_req;
  logic [CNT_W-1:0] cycle_limit;
  logic             cpu_rst_n, cpu_rd_wrn;
  logic [31:0]      cpu_addr, cpu_wdata;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_count;

  always #5 clk = ~clk;

  run_ctrl_if bus ();

  run_ctrl #(.DMEM_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK100MHZ       (clk),
    .RST             (rst),
    .RUN_REQ         (run_req),
    .DUMP_REQ        (dump_req),
    .CYCLE_LIMIT     (cycle_limit),
    .CPU_RST_N       (cpu_rst_n),
    .CPU_DMEM_RD_WRN (cpu_rd_wrn),
    .CPU_DMEM_ADDR   (cpu_addr),
    .CPU_DMEM_WDATA  (cpu_wdata),
    .bus             (bus.master),
    .STATE           (state),
    .CYCLE_COUNT     (cycle_count)
  );

  // Environment dmem: combinational read, write on the rising edge.
  logic [31:0] env_mem [MEMW];
  always_comb begin
    if (bus.MEM_ADDR < MEMW) bus.MEM_RDATA = env_mem[bus.MEM_ADDR[3:0]];
    else                     bus.MEM_RDATA = {16'hdead, bus.MEM_ADDR[15:0]};
  end
  always @(posedge clk)
    if (bus.MEM_RD_WRN === 1'b0 && bus.MEM_ADDR < MEMW)
      env_mem[bus.MEM_ADDR[3:0]] <= bus.MEM_WDATA;

  int total = 0;
  int bad   = 0;
  int run_hi = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int               mode;
    bit               rst_n;
    bit               rd_wrn;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    bit               valid;
    logic [31:0]      daddr;
    logic [31:0]      ddata;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } dw_t;

  exp_t exp_q[$];
  dw_t  dump_q[$];

  // Reference model state, expressed in terms of the observable rules.
  int               m_mode;
  logic [CNT_W-1:0] m_cnt;
  int               m_ptr;
  bit               m_prev;
  bit               run_p[2];
  bit               dump_p[2];
  logic [31:0]      m_mem [MEMW];

  function automatic logic [31:0] m_rd(input int a);
    return (a < MEMW) ? m_mem[a] : {16'hdead, 16'(a)};
  endfunction

  task automatic model_reset();
    m_mode = M_HOLD; m_cnt = '0; m_ptr = 0; m_prev = 0;
    run_p = '{0, 0}; dump_p = '{0, 0};
  endtask

  // Record what this cycle must look like, then advance the model across the edge.
  task automatic step();
    exp_t  e;
    bit    run_eff, dump_eff, rise;
    longint spent;
    run_eff  = (LAT == 0) ? run_req  : run_p[1];
    dump_eff = (LAT == 0) ? dump_req : dump_p[1];
    rise     = run_eff && !m_prev;

    e.mode   = m_mode;
    e.rst_n  = (m_mode == M_RUN);
    e.rd_wrn = (m_mode == M_RUN) ? cpu_rd_wrn : 1'b1;
    e.addr   = (m_mode == M_RUN) ? cpu_addr : (m_mode == M_DUMP) ? 32'(m_ptr) : 32'd0;
    e.wdata  = (m_mode == M_RUN) ? cpu_wdata : 32'd0;
    e.valid  = (m_mode == M_DUMP);
    e.daddr  = 32'(m_ptr);
    e.ddata  = m_rd(m_ptr);
    e.cnt    = m_cnt;
    exp_q.push_back(e);

    if (m_mode == M_DUMP && bus.DUMP_READY) dump_q.push_back('{32'(m_ptr), m_rd(m_ptr)});
    if (m_mode == M_RUN && !cpu_rd_wrn && cpu_addr < MEMW) m_mem[cpu_addr[3:0]] = cpu_wdata;

    if (rst) begin
      model_reset();
    end else begin
      case (m_mode)
        M_HOLD: if (rise) begin m_mode = M_RUN; m_cnt = '0; end
        M_RUN: begin
          spent = longint'(m_cnt) + 1;
          if (m_cnt != '1) m_cnt = m_cnt + 1;
          if (!run_eff || (cycle_limit != 0 && spent == longint'(cycle_limit))) m_mode = M_DONE;
        end
        M_DONE: begin
          if (rise) begin m_mode = M_RUN; m_cnt = '0; end
          else if (dump_eff) begin m_mode = M_DUMP; m_ptr = 0; end
        end
        default: begin
          if (bus.DUMP_READY) begin
            if (m_ptr == DEPTH - 1) begin m_mode = M_DONE; m_ptr = 0; end
            else m_ptr++;
          end
        end
      endcase
      m_prev    = run_eff;
      run_p[1]  = run_p[0];  run_p[0]  = run_req;
      dump_p[1] = dump_p[0]; dump_p[0] = dump_req;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mode(input string name, input int target, input int budget);
    for (int i = 0; i < budget && m_mode != target; i++) step();
    #1;
    check(name, state, target);
  endtask

  // Monitor: per-cycle comparison plus a separate check on every dump transfer.
  initial begin
    exp_t e;
    dw_t  w;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",       state,          e.mode);
        check("cpu_rst_n",   cpu_rst_n,      e.rst_n);
        check("mem_rd_wrn",  bus.MEM_RD_WRN, e.rd_wrn);
        check("mem_addr",    bus.MEM_ADDR,   e.addr);
        check("mem_wdata",   bus.MEM_WDATA,  e.wdata);
        check("dump_valid",  bus.DUMP_VALID, e.valid);
        check("cycle_count", cycle_count,    e.cnt);
        if (e.valid) begin
          check("dump_addr", bus.DUMP_ADDR, e.daddr);
          check("dump_data", bus.DUMP_DATA, e.ddata);
        end
        if (cpu_rst_n === 1'b1) run_hi++;
      end
      if (bus.DUMP_VALID === 1'b1 && bus.DUMP_READY === 1'b1) begin
        check("dump_xfer_expected", 64'(dump_q.size() > 0), 64'd1);
        if (dump_q.size() > 0) begin
          w = dump_q.pop_front();
          check("xfer_addr", bus.DUMP_ADDR, w.a);
          check("xfer_data", bus.DUMP_DATA, w.d);
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    rst = 1; run_req = 0; dump_req = 0; cycle_limit = '0;
    cpu_rd_wrn = 1; cpu_addr = '0; cpu_wdata = '0; bus.DUMP_READY = 0;
    for (int i = 0; i < MEMW; i++) begin
      v = $urandom; env_mem[i] = v; m_mem[i] = v;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",      state,          0);
    check("rst_cpu_rst_n",  cpu_rst_n,      0);
    check("rst_dump_valid", bus.DUMP_VALID, 0);
    check("rst_mem_rd_wrn", bus.MEM_RD_WRN, 1);
    check("rst_count",      cycle_count,    0);
    step();
    rst = 0;

    // Budget of 5 cycles.
    cycle_limit = 5;
    step();
    run_hi = 0;
    run_req = 1;
    repeat (12) step();
    check("lim5_run_cycles", run_hi, 5);
    check("lim5_count", cycle_count, 5);
    check("lim5_state", state, M_DONE);

    // Unlimited run ended by the switch after 100 cycles.
    run_req = 0; cycle_limit = 0;
    repeat (3) step();
    run_hi = 0;
    run_req = 1;
    repeat (100) step();
    run_req = 0;
    repeat (4) step();
    check("unl_run_cycles", run_hi, 100);
    check("unl_count", cycle_count, 100);
    check("unl_state", state, M_DONE);

    // CPU write passes through in RUN only.
    run_req = 1;
    wait_mode("enter_run_wr", M_RUN, 8);
    cpu_rd_wrn = 0; cpu_addr = 1; cpu_wdata = 32'h7;
    #1;
    check("run_wr_addr",  bus.MEM_ADDR,   1);
    check("run_wr_data",  bus.MEM_WDATA,  32'h7);
    check("run_wr_rdwrn", bus.MEM_RD_WRN, 0);
    step();
    run_req = 0;
    wait_mode("enter_done_wr", M_DONE, 8);
    check("done_wr_rdwrn", bus.MEM_RD_WRN, 1);
    check("done_wr_addr",  bus.MEM_ADDR,   0);
    step();
    cpu_rd_wrn = 1;

    // Dump with a stalled consumer, then full sweep.
    bus.DUMP_READY = 0;
    dump_req = 1;
    wait_mode("enter_dump", M_DUMP, 6);
    dump_req = 0;
    repeat (4) begin
      #1;
      check("stall_addr", bus.DUMP_ADDR, 0);
      check("stall_valid", bus.DUMP_VALID, 1);
      step();
    end
    bus.DUMP_READY = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("sweep_addr", bus.DUMP_ADDR, i);
      step();
    end
    #1;
    check("sweep_end_state", state, M_DONE);

    // Reset in the middle of a dump.
    dump_req = 1;
    wait_mode("enter_dump2", M_DUMP, 6);
    dump_req = 0;
    repeat (3) step();
    #1;
    check("mid_dump_addr", bus.DUMP_ADDR, 3);
    rst = 1;
    step();
    rst = 0;
    #1;
    check("rst_dump_state", state, M_HOLD);
    check("rst_dump_valid2", bus.DUMP_VALID, 0);
    check("rst_dump_ptr", bus.DUMP_ADDR, 0);

    // Run rise beats dump request in DONE.
    run_req = 1;
    wait_mode("enter_run3", M_RUN, 8);
    run_req = 0;
    wait_mode("enter_done3", M_DONE, 8);
    run_req = 1; dump_req = 1;
    wait_mode("prio_state", M_RUN, 4);
    check("prio_count", cycle_count, 0);
    run_req = 0; dump_req = 0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) run_req = ~run_req;
      if ($urandom_range(0, 24) == 0) dump_req = ~dump_req;
      if ($urandom_range(0, 49) == 0)
        cycle_limit = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 30));
      bus.DUMP_READY = ($urandom_range(0, 2) != 0);
      cpu_rd_wrn = 1'($urandom_range(0, 1));
      cpu_addr   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, MEMW - 1));
      cpu_wdata  = $urandom;
      rst        = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    #20;
    check("exp_q_drained",  exp_q.size(),  0);
    check("dump_q_drained", dump_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter DMEM_DEPTH, default 10: number of dmem words swept in DUMP; addresses 0..DMEM_DEPTH-1.
REQ-002 Parameter CNT_W, default 32: cycle counter width.
REQ-003 CLK100MHZ  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 RUN_REQ  in  1  level run request (switch).
REQ-006 DUMP_REQ  in  1  level dump request (switch).
REQ-007 CYCLE_LIMIT  in  CNT_W  run cycle budget; 0 = unlimited.
REQ-008 CPU_RST_N  out  1  active-low reset to the CPU.
REQ-009 CPU_DMEM_RD_WRN  in  1  CPU dmem strobe; 0 = write.
REQ-010 CPU_DMEM_ADDR  in  32  CPU dmem address.
REQ-011 CPU_DMEM_WDATA  in  32  CPU dmem write data.
REQ-012 MEM_RD_WRN  out  1  strobe to dmem; 0 = write.
REQ-013 MEM_ADDR  out  32  address to dmem.
REQ-014 MEM_WDATA  out  32  write data to dmem.
REQ-015 MEM_RDATA  in  32  combinational dmem read data.
REQ-016 DUMP_VALID  out  1  dump word available.
REQ-017 DUMP_READY  in  1  consumer accepts dump word.
REQ-018 DUMP_ADDR  out  32  address of current dump word.
REQ-019 DUMP_DATA  out  32  current dump word.
REQ-020 STATE  out  2  HOLD=0, RUN=1, DONE=2, DUMP=3 (LED drive).
REQ-021 CYCLE_COUNT  out  CNT_W  cycles spent in RUN.

Function
REQ-022 Rising edge of RUN_REQ (sampled 0 then 1 in consecutive cycles) = run_rise; DUMP_REQ level 1 = dump_req.
REQ-023 HOLD: CPU_RST_N=0; run_rise -> RUN next cycle, CYCLE_COUNT cleared to 0.
REQ-024 RUN: CPU_RST_N=1; MEM_* = CPU_DMEM_* pass-through, zero latency; CYCLE_COUNT +1 per cycle, saturating at all-ones.
REQ-025 RUN exit -> DONE when RUN_REQ=0, or CYCLE_LIMIT!=0 and CYCLE_COUNT==CYCLE_LIMIT-1 (exactly CYCLE_LIMIT RUN cycles).
REQ-026 DONE: CPU_RST_N=0; MEM_RD_WRN forced 1; CYCLE_COUNT held; run_rise -> RUN (count cleared); else dump_req -> DUMP, dump pointer=0; run_rise wins when simultaneous.
REQ-027 DUMP: CPU_RST_N=0; MEM_RD_WRN=1; MEM_ADDR=DUMP_ADDR=pointer; DUMP_DATA=MEM_RDATA; DUMP_VALID=1.
REQ-028 DUMP handshake: pointer advances only on DUMP_VALID&DUMP_READY; DUMP_ADDR/DUMP_DATA stable while VALID&!READY.
REQ-029 Handshake at pointer==DMEM_DEPTH-1 -> DONE, pointer=0; no wrap within DUMP.
REQ-030 RUN_REQ/DUMP_REQ changes during DUMP ignored until DONE.
REQ-031 Outside RUN and DUMP: MEM_ADDR=0, MEM_WDATA=0, MEM_RD_WRN=1; DUMP_VALID=0 outside DUMP.
REQ-032 CPU writes never reach dmem while CPU_RST_N=0.

Reset
REQ-033 RST=1: state HOLD, CYCLE_COUNT=0, pointer=0, edge/sync registers 0, CPU_RST_N=0, DUMP_VALID=0, MEM_RD_WRN=1, STATE=0.
REQ-034 RST overrides every state incl. mid-RUN and mid-DUMP; RUN_REQ high at RST release counts as run_rise one cycle later.

Configuration
REQ-035 Macro RUN_CTRL_SYNC_EN defined: RUN_REQ and DUMP_REQ pass a 2-flop synchronizer before edge/level detection, adding 2 cycles to every input response.
REQ-036 RUN_CTRL_SYNC_EN undefined: inputs sampled directly; RUN entered the cycle after the first cycle RUN_REQ=1.

Verification
REQ-037 RST then RUN_REQ 0->1, CYCLE_LIMIT=5 -> CPU_RST_N=1 exactly 5 cycles, STATE 0->1->2, CYCLE_COUNT=5.
REQ-038 CYCLE_LIMIT=0, RUN_REQ high 100 cycles then low -> DONE, CYCLE_COUNT=100.
REQ-039 RUN with CPU write addr 1 data 0x7 -> MEM_ADDR=1, MEM_WDATA=0x7, MEM_RD_WRN=0 same cycle; identical stimulus in DONE -> MEM_RD_WRN=1.
REQ-040 DUMP, DUMP_READY held low 4 cycles then high -> DUMP_ADDR=0 stable, then 0..9 one per cycle, DONE after addr 9.
REQ-041 RST asserted mid-DUMP at addr 3 -> next cycle STATE=0, DUMP_VALID=0, pointer 0.
REQ-042 In DONE, RUN_REQ rise and DUMP_REQ=1 same cycle -> STATE=1, CYCLE_COUNT=0.
